// File: rtl/mem_stage_controller_pkg.sv
// Shared parameters for the memory-stage controller: state encoding and defaults.
package mem_stage_controller_pkg;

  localparam int unsigned DEFAULT_WORD_WIDTH     = 32;
  localparam int unsigned DEFAULT_TIMEOUT_CYCLES = 64;
  localparam int unsigned STALL_CNT_WIDTH        = 32;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'b00,
    ST_ACCESS   = 2'b01,
    ST_COMPLETE = 2'b10
  } mem_state_e;

  // Bits needed to hold a count of 0..max_count inclusive.
  function automatic int unsigned cnt_width(input int unsigned max_count);
    return $clog2(max_count + 1);
  endfunction

endpackage

// File: rtl/mem_stage_controller.sv
// Memory-stage controller: accepts load/store from EX, runs one cache access with timeout.
// Optional MEM_STALL_COUNTER_EN adds a saturating stall_cycles counter output.
module mem_stage_controller
  import mem_stage_controller_pkg::*;
#(
  parameter int unsigned WORD_WIDTH     = DEFAULT_WORD_WIDTH,
  parameter int unsigned TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  alu_op_done,
  input  logic                  cu_mem_read_in,
  input  logic                  cu_mem_write_in,
  input  logic [WORD_WIDTH-1:0] alu_result_in,
  input  logic                  mem_ready,
  output logic                  mem_req,
  output logic [WORD_WIDTH-1:0] mem_addr,
  output logic                  mem_write,
  output logic                  mem_reg_enable,
  output logic                  stall_out,
  output logic                  err_timeout
`ifdef MEM_STALL_COUNTER_EN
  ,
  output logic [STALL_CNT_WIDTH-1:0] stall_cycles
`endif
);

  localparam int unsigned CNT_WIDTH = cnt_width(TIMEOUT_CYCLES);
  // Count value at the start of the last ACCESS cycle allowed before timing out.
  localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(TIMEOUT_CYCLES - 1);

  mem_state_e           state;
  logic [CNT_WIDTH-1:0] timeout_cnt;
  logic                 mem_op_c;

  assign mem_op_c = alu_op_done & (cu_mem_read_in | cu_mem_write_in);

  // State, latched access attributes, timeout counter and sticky error.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= ST_IDLE;
      mem_addr    <= '0;
      mem_write   <= 1'b0;
      timeout_cnt <= '0;
      err_timeout <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (mem_op_c) begin
            mem_addr    <= alu_result_in;
            mem_write   <= cu_mem_write_in;
            timeout_cnt <= '0;
            state       <= ST_ACCESS;
          end
        end
        ST_ACCESS: begin
          // A ready in the final allowed cycle wins over the timeout.
          if (mem_ready) begin
            state <= ST_COMPLETE;
          end else begin
            timeout_cnt <= timeout_cnt + CNT_WIDTH'(1);
            if (timeout_cnt == CNT_LAST) begin
              err_timeout <= 1'b1;
              state       <= ST_COMPLETE;
            end
          end
        end
        ST_COMPLETE: state <= ST_IDLE;
        default:     state <= ST_IDLE;
      endcase
    end
  end

  // Handshake outputs; accept-cycle stall and pass-through enable react to EX directly.
  always_comb begin
    mem_req        = 1'b0;
    stall_out      = 1'b0;
    mem_reg_enable = 1'b0;
    if (!reset) begin
      case (state)
        ST_IDLE: begin
          stall_out      = mem_op_c;
          mem_reg_enable = alu_op_done & ~mem_op_c;
        end
        ST_ACCESS: begin
          mem_req   = 1'b1;
          stall_out = 1'b1;
        end
        ST_COMPLETE: mem_reg_enable = 1'b1;
        default: ;
      endcase
    end
  end

`ifdef MEM_STALL_COUNTER_EN
  // Saturating count of stalled cycles since reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cycles <= '0;
    end else if (stall_out && (stall_cycles != '1)) begin
      stall_cycles <= stall_cycles + STALL_CNT_WIDTH'(1);
    end
  end
`endif

endmodule

// File: tb/tb_mem_stage_controller.sv
// Scoreboard bench for mem_stage_controller: random load/store/non-mem traffic plus directed cases.
module tb_mem_stage_controller;

  localparam int unsigned TO = 6;

  logic        clk = 1'b0;
  logic        reset;
  logic        alu_op_done, cu_mem_read_in, cu_mem_write_in, mem_ready;
  logic [31:0] alu_result_in;
  logic        mem_req, mem_write, mem_reg_enable, stall_out, err_timeout;
  logic [31:0] mem_addr;

  logic        b_alu_op_done, b_rd, b_wr, b_mem_ready;
  logic [31:0] b_alu_result;
  logic        b_mem_req, b_mem_write, b_mem_reg_enable, b_stall_out, b_err_timeout;
  logic [31:0] b_mem_addr;
`ifdef MEM_STALL_COUNTER_EN
  logic [31:0] stall_cycles, b_stall_cycles;
`endif

  always #5 clk = ~clk;

  mem_stage_controller #(.WORD_WIDTH(32), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset(reset), .alu_op_done(alu_op_done),
    .cu_mem_read_in(cu_mem_read_in), .cu_mem_write_in(cu_mem_write_in),
    .alu_result_in(alu_result_in), .mem_ready(mem_ready), .mem_req(mem_req),
    .mem_addr(mem_addr), .mem_write(mem_write), .mem_reg_enable(mem_reg_enable),
    .stall_out(stall_out), .err_timeout(err_timeout)
`ifdef MEM_STALL_COUNTER_EN
    , .stall_cycles(stall_cycles)
`endif
  );

  mem_stage_controller #(.WORD_WIDTH(32), .TIMEOUT_CYCLES(4)) dut4 (
    .clk(clk), .reset(reset), .alu_op_done(b_alu_op_done),
    .cu_mem_read_in(b_rd), .cu_mem_write_in(b_wr),
    .alu_result_in(b_alu_result), .mem_ready(b_mem_ready), .mem_req(b_mem_req),
    .mem_addr(b_mem_addr), .mem_write(b_mem_write), .mem_reg_enable(b_mem_reg_enable),
    .stall_out(b_stall_out), .err_timeout(b_err_timeout)
`ifdef MEM_STALL_COUNTER_EN
    , .stall_cycles(b_stall_cycles)
`endif
  );

  // Expected outcome of one EX hand-off, as seen when mem_reg_enable fires.
  typedef struct {
    bit          is_mem;
    logic [31:0] addr;
    bit          wr;
    int          n_acc;
    bit          err;
  } exp_t;

  exp_t exp_q[$];
  int   vectors = 0;
  int   miscompares = 0;
  bit   err_model = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Monitor: accumulates per-transaction observations, scores on each mem_reg_enable.
  int          req_cyc = 0, stall_cyc = 0;
  logic [31:0] first_addr = '0;
  bit          addr_moved = 1'b0;
  exp_t        e;

  always @(negedge clk) begin
    if (reset) begin
      req_cyc = 0; stall_cyc = 0; addr_moved = 1'b0;
    end else begin
      if (mem_req) begin
        if (req_cyc == 0) first_addr = mem_addr;
        else if (mem_addr !== first_addr) addr_moved = 1'b1;
        req_cyc++;
      end
      if (stall_out) stall_cyc++;
      if (mem_reg_enable) begin
        if (exp_q.size() == 0) begin
          check("reg_enable_without_op", 64'(exp_q.size()), 64'd1);
        end else begin
          e = exp_q.pop_front();
          check("req_cycles", 64'(req_cyc), e.is_mem ? 64'(e.n_acc) : 64'd0);
          check("stall_cycles_seen", 64'(stall_cyc), e.is_mem ? 64'(e.n_acc + 1) : 64'd0);
          check("err_timeout", 64'(err_timeout), 64'(e.err));
          if (e.is_mem) begin
            check("mem_addr", 64'(first_addr), 64'(e.addr));
            check("mem_write", 64'(mem_write), 64'(e.wr));
            check("addr_stable", 64'(addr_moved), 64'd0);
          end
        end
        req_cyc = 0; stall_cyc = 0; addr_moved = 1'b0;
      end
    end
  end

  task automatic idle_cycle();
    alu_op_done = 1'b0;
    cu_mem_read_in = 1'($urandom); cu_mem_write_in = 1'($urandom);
    alu_result_in = $urandom; mem_ready = 1'($urandom);
    step();
  endtask

  task automatic do_nonmem(input logic [31:0] addr);
    exp_t x;
    alu_op_done = 1'b1; cu_mem_read_in = 1'b0; cu_mem_write_in = 1'b0;
    alu_result_in = addr; mem_ready = 1'($urandom);
    x.is_mem = 1'b0; x.addr = addr; x.wr = 1'b0; x.n_acc = 0; x.err = err_model;
    exp_q.push_back(x);
    step();
    alu_op_done = 1'b0; mem_ready = 1'b0;
  endtask

  // n = ACCESS cycle on which the cache answers; beyond TO the access times out.
  task automatic do_mem(input logic [31:0] addr, input bit rd, input bit wr, input int n);
    exp_t x;
    int   n_acc;
    n_acc = (n > int'(TO)) ? int'(TO) : n;
    if (n > int'(TO)) err_model = 1'b1;
    alu_op_done = 1'b1; cu_mem_read_in = rd; cu_mem_write_in = wr;
    alu_result_in = addr; mem_ready = 1'($urandom);
    x.is_mem = 1'b1; x.addr = addr; x.wr = wr; x.n_acc = n_acc; x.err = err_model;
    exp_q.push_back(x);
    step();
    for (int k = 1; k <= n_acc; k++) begin
      alu_op_done = 1'($urandom); cu_mem_read_in = 1'($urandom);
      cu_mem_write_in = 1'($urandom); alu_result_in = $urandom;
      mem_ready = (k == n);
      step();
    end
    alu_op_done = 1'b1; cu_mem_read_in = 1'($urandom); cu_mem_write_in = 1'b1;
    alu_result_in = $urandom; mem_ready = 1'($urandom);
    step();
    alu_op_done = 1'b0; mem_ready = 1'b0;
  endtask

  task automatic do_random(input int count);
    int  kind;
    bit  rd, wr;
    for (int i = 0; i < count; i++) begin
      kind = int'($urandom_range(0, 3));
      if (kind == 0) do_nonmem($urandom);
      else if (kind == 1) idle_cycle();
      else begin
        {rd, wr} = 2'($urandom_range(1, 3));
        do_mem($urandom, rd, wr, int'($urandom_range(1, TO + 2)));
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    alu_op_done = 1'b0; cu_mem_read_in = 1'b0; cu_mem_write_in = 1'b0;
    alu_result_in = '0; mem_ready = 1'b0;
    b_alu_op_done = 1'b0; b_rd = 1'b0; b_wr = 1'b0; b_alu_result = '0; b_mem_ready = 1'b0;
    #12;
    check("rst_mem_req", 64'(mem_req), 64'd0);
    check("rst_stall_out", 64'(stall_out), 64'd0);
    check("rst_mem_reg_enable", 64'(mem_reg_enable), 64'd0);
    check("rst_mem_addr", 64'(mem_addr), 64'd0);
    check("rst_mem_write", 64'(mem_write), 64'd0);
    check("rst_err_timeout", 64'(err_timeout), 64'd0);
`ifdef MEM_STALL_COUNTER_EN
    check("rst_stall_cycles", 64'(stall_cycles), 64'd0);
`endif
    step();
    reset = 1'b0;
    step();

    // Store, cache answers on the 5th ACCESS cycle.
    do_mem(32'h0000_0080, 1'b0, 1'b1, 5);
`ifdef MEM_STALL_COUNTER_EN
    check("stall_cycles_after_store", 64'(stall_cycles), 64'd6);
`endif
    do_nonmem(32'h0000_0010);
    do_mem(32'h0000_0040, 1'b1, 1'b0, 1);
    do_mem(32'h0000_00C0, 1'b1, 1'b1, int'(TO));
    do_random(150);

    // Reset pulsed in the third ACCESS cycle of a load.
    alu_op_done = 1'b1; cu_mem_read_in = 1'b1; cu_mem_write_in = 1'b0;
    alu_result_in = 32'h0000_0200; mem_ready = 1'b0;
    step();
    alu_op_done = 1'b0;
    step();
    step();
    check("pre_reset_mem_req", 64'(mem_req), 64'd1);
    #2 reset = 1'b1;
    #1;
    check("async_rst_mem_req", 64'(mem_req), 64'd0);
    check("async_rst_stall_out", 64'(stall_out), 64'd0);
    check("async_rst_mem_addr", 64'(mem_addr), 64'd0);
    check("async_rst_err", 64'(err_timeout), 64'd0);
    err_model = 1'b0;
    @(negedge clk);
    #1 reset = 1'b0;
    step();
    do_mem(32'h0000_0300, 1'b1, 1'b0, 2);
    do_random(40);

    // Second instance with a 4-cycle timeout and a silent cache.
    b_alu_op_done = 1'b1; b_wr = 1'b1; b_alu_result = 32'h0000_0100; b_mem_ready = 1'b0;
    #1 check("t4_accept_stall", 64'(b_stall_out), 64'd1);
    step();
    b_alu_op_done = 1'b0; b_wr = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      #1 check("t4_access_req", 64'(b_mem_req), 64'd1);
      step();
    end
    check("t4_req_dropped", 64'(b_mem_req), 64'd0);
    check("t4_err_set", 64'(b_err_timeout), 64'd1);
    check("t4_complete_enable", 64'(b_mem_reg_enable), 64'd1);
    step();
    b_alu_op_done = 1'b1; b_rd = 1'b1; b_alu_result = 32'h0000_0104;
    step();
    b_alu_op_done = 1'b0; b_rd = 1'b0; b_mem_ready = 1'b1;
    #1 check("t4_second_req", 64'(b_mem_req), 64'd1);
    step();
    b_mem_ready = 1'b0;
    check("t4_second_complete", 64'(b_mem_reg_enable), 64'd1);
    check("t4_err_sticky", 64'(b_err_timeout), 64'd1);
    step();
    check("t4_err_sticky_idle", 64'(b_err_timeout), 64'd1);

    step();
    check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mem_stage_controller.md
MEM_STAGE_CONTROLLER -- requirements
Module: mem_stage_controller

Interface
REQ-001 Parameter WORD_WIDTH, default 32, width of ALU result and memory address.
REQ-002 Parameter TIMEOUT_CYCLES, default 64, maximum ACCESS cycles before timeout; legal range 1..65535.
REQ-003 clk  in  1  single clock, all state updates on posedge.
REQ-004 reset  in  1  asynchronous, active-high reset.
REQ-005 alu_op_done  in  1  EX result valid this cycle.
REQ-006 cu_mem_read_in  in  1  EX instruction is a load.
REQ-007 cu_mem_write_in  in  1  EX instruction is a store.
REQ-008 alu_result_in  in  WORD_WIDTH  effective address from ALU.
REQ-009 mem_ready  in  1  data cache completes the current access.
REQ-010 mem_req  out  1  level request to data cache.
REQ-011 mem_addr  out  WORD_WIDTH  latched access address.
REQ-012 mem_write  out  1  1 = store, 0 = load; valid while mem_req=1.
REQ-013 mem_reg_enable  out  1  load enable for the memory-stage pipeline registers.
REQ-014 stall_out  out  1  freeze IF/ID/EX stages.
REQ-015 err_timeout  out  1  sticky access-timeout flag.

Function
REQ-016 FSM states: IDLE, ACCESS, COMPLETE; encoding 2 bits.
REQ-017 A memory op is defined as alu_op_done & (cu_mem_read_in | cu_mem_write_in).
REQ-018 IDLE, non-memory op (alu_op_done=1, no read/write): mem_reg_enable=1 combinationally in the same cycle; FSM stays IDLE.
REQ-019 IDLE, memory op: latch alu_result_in into mem_addr and cu_mem_write_in into mem_write; go to ACCESS; stall_out=1 combinationally in the same cycle; mem_reg_enable=0.
REQ-020 Read and write both asserted: the access is a store (mem_write=1).
REQ-021 ACCESS: mem_req=1, stall_out=1; on mem_ready=1 go to COMPLETE; mem_addr/mem_write stay stable.
REQ-022 COMPLETE: mem_reg_enable=1 and stall_out=0 for exactly one cycle; mem_req=0; next state IDLE.
REQ-023 Latency from memory-op accept to mem_reg_enable = N+1 cycles, where N = ACCESS cycles (N>=1).
REQ-024 alu_op_done is ignored in ACCESS and COMPLETE; no new memory op is accepted in COMPLETE.
REQ-025 Timeout counter, width ceil(log2(TIMEOUT_CYCLES+1)), clears on entry to ACCESS and increments each ACCESS cycle without mem_ready.
REQ-026 Counter reaching TIMEOUT_CYCLES: set err_timeout, drop mem_req, go to COMPLETE.
REQ-027 mem_ready arriving in the same cycle the count reaches TIMEOUT_CYCLES: normal completion; err_timeout is not set.
REQ-028 mem_ready outside ACCESS is ignored.

Reset
REQ-029 Reset asserted at any time, including mid-access, immediately forces: state IDLE, mem_req=0, mem_addr=0, mem_write=0, mem_reg_enable=0, stall_out=0, err_timeout=0, counter=0.
REQ-030 err_timeout clears only on reset.

Configuration
REQ-031 Macro MEM_STALL_COUNTER_EN defined: add output stall_cycles (32 bits); it increments every cycle stall_out=1, saturates at 0xFFFFFFFF, and resets to 0.
REQ-032 MEM_STALL_COUNTER_EN undefined: no stall_cycles port and no counter logic; all other behaviour is identical.

Structure
REQ-033 FSM state encodings and the default TIMEOUT_CYCLES value live in the shared parameters file; WORD_WIDTH is taken from it.
REQ-034 Single module, no sub-modules; the optional stall counter is inline, under the macro.

Verification
REQ-035 Non-memory op at alu_result_in=0x10 in IDLE -> mem_reg_enable=1 the same cycle, stall_out=0, mem_req never asserted.
REQ-036 Load at 0x0000_0040, mem_ready on the first ACCESS cycle -> mem_req=1 for one cycle, mem_write=0, mem_reg_enable=1 two cycles after accept.
REQ-037 Store at 0x0000_0080, mem_ready after 5 cycles -> stall_out=1 for 6 cycles, mem_addr stable at 0x80, mem_write=1, then a one-cycle COMPLETE.
REQ-038 TIMEOUT_CYCLES=4, mem_ready held low -> mem_req drops after 4 ACCESS cycles, err_timeout=1 and stays 1 through later ops.
REQ-039 Reset pulsed in the third ACCESS cycle -> mem_req=0 and stall_out=0 without waiting for a clock edge; FSM is IDLE; the next load completes normally.
REQ-040 MEM_STALL_COUNTER_EN defined, run REQ-037 -> stall_cycles=6.
